// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out stream serializer.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width for a word of 'width' bits; never narrower than one bit.
  function automatic int cnt_w(input int width);
    if (width <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(width);
    end
  endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for serializers: clear on a new word, step per sent bit,
// and flag the final bit position of the word.
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_VAL = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_r;

  // Clear has priority so a new word loaded on the final bit starts at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == LAST_VAL);

endmodule

// File: rtl/piso_stream.sv
// Parallel-in serial-out shift register with ready/valid on both sides and
// gap-free back-to-back word loading.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_last
);

  localparam int OUT_IDX = MSB_FIRST ? (WIDTH - 1) : 0;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] sreg_r;
  logic             cnt_last_s;
  logic             load_xfer_s;
  logic             ser_xfer_s;

  assign load_xfer_s = load_valid & load_ready;
  assign ser_xfer_s  = ser_valid & ser_ready;

  piso_bit_cnt #(
    .WIDTH(WIDTH)
  ) u_bit_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (load_xfer_s),
    .inc  (ser_xfer_s),
    .last (cnt_last_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: the final bit returns to IDLE unless a new word is taken alongside it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_xfer_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (ser_xfer_s && ser_last && !load_xfer_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs; load_ready opens on the accepted final bit to allow zero-gap reloads.
  always_comb begin
    ser_valid  = 1'b0;
    ser_last   = 1'b0;
    ser_out    = IDLE_BIT;
    load_ready = 1'b0;
    case (state_r)
      IDLE: begin
        load_ready = rst_n;
      end
      SHIFT: begin
        ser_valid  = 1'b1;
        ser_last   = cnt_last_s;
        ser_out    = sreg_r[OUT_IDX];
        load_ready = rst_n & cnt_last_s & ser_ready;
      end
      default: begin
        load_ready = 1'b0;
      end
    endcase
  end

  // Shift register: load a word, or move the next bit into the output position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg_r <= '0;
    end else if (load_xfer_s) begin
      sreg_r <= load_data;
    end else if (ser_xfer_s) begin
      sreg_r <= MSB_FIRST ? (sreg_r << 1) : (sreg_r >> 1);
    end else begin
      sreg_r <= sreg_r;
    end
  end

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: three configurations, a vector table
// and hand-written sequences, with a scoreboard of expected serial bits.
module tb_piso_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       lv [3];
  logic       lr [3];
  logic       sv [3];
  logic       sr [3];
  logic       so [3];
  logic       sl [3];
  logic [7:0] ld [3];

  // Instance 0: 4-bit MSB-first; 1: 8-bit LSB-first, idle bit 1; 2: 1-bit.
  piso_stream #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w4 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld[0][3:0]), .ser_valid(sv[0]), .ser_ready(sr[0]),
    .ser_out(so[0]), .ser_last(sl[0]));
  piso_stream #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld[1]), .ser_valid(sv[1]), .ser_ready(sr[1]),
    .ser_out(so[1]), .ser_last(sl[1]));
  piso_stream #(.WIDTH(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(lr[2]),
    .load_data(ld[2][0:0]), .ser_valid(sv[2]), .ser_ready(sr[2]),
    .ser_out(so[2]), .ser_last(sl[2]));

  typedef struct packed {
    logic [1:0] inst;
    logic       b;
    logic       last;
  } exp_t;

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [7:0] exp;  // exp[k] is the k-th bit expected on ser_out
  } vec_t;

  exp_t       q[$];
  int         errs = 0;
  int         chks = 0;
  int         wid [3] = '{4, 8, 1};
  logic       idle_bit [3] = '{1'b0, 1'b1, 1'b0};
  logic [7:0] cur_exp [3];
  vec_t       vecs [6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    chks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: score serial transfers and record new words at the falling edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (sv[i] && sr[i]) begin
        if (q.size() == 0) begin
          chks++;
          errs++;
          $display("FAIL unexpected_bit: inst %0d emitted %0b with no word pending", i, so[i]);
        end else begin
          e = q.pop_front();
          check("ser_bit", {2'b00, i[1:0], so[i], sl[i], lr[i]},
                {2'b00, e.inst, e.b, e.last, e.last});
        end
      end
      if (lv[i] && lr[i]) begin
        for (int k = 0; k < wid[i]; k++) begin
          e.inst = i[1:0];
          e.b    = cur_exp[i][k];
          e.last = (k == wid[i] - 1);
          q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [7:0] d, input logic [7:0] exp,
                      input bit keep, input bit on_last);
    int n;
    cur_exp[i] = exp;
    ld[i]      = d;
    lv[i]      = 1'b1;
    for (n = 0; n < 40; n++) begin
      if (lr[i]) break;
      tick();
    end
    if (n == 40) begin
      chks++;
      errs++;
      $display("FAIL load_timeout: inst %0d load_ready never rose", i);
    end
    if (on_last) check("reload_on_last", {7'd0, sl[i]}, 8'd1);
    tick();
    if (!keep) lv[i] = 1'b0;
    check("first_bit_valid", {7'd0, sv[i]}, 8'd1);
  endtask

  task automatic drain(input int i);
    int n;
    for (n = 0; n < 60; n++) begin
      if (!sv[i] && q.size() == 0) break;
      tick();
    end
    if (n == 60) begin
      chks++;
      errs++;
      $display("FAIL drain_timeout: inst %0d still busy, %0d bits pending", i, q.size());
    end
    check("idle_valid", {7'd0, sv[i]}, 8'd0);
    check("idle_out", {7'd0, so[i]}, {7'd0, idle_bit[i]});
    check("idle_ready", {7'd0, lr[i]}, 8'd1);
  endtask

  initial begin
    vecs[0] = '{0, 8'h0B, 8'h0D};  // 1011 -> 1,0,1,1
    vecs[1] = '{1, 8'hA5, 8'hA5};  // LSB-first -> 1,0,1,0,0,1,0,1
    vecs[2] = '{0, 8'h06, 8'h06};  // 0110 -> 0,1,1,0
    vecs[3] = '{1, 8'h3C, 8'h3C};  // -> 0,0,1,1,1,1,0,0
    vecs[4] = '{2, 8'h01, 8'h01};
    vecs[5] = '{0, 8'h08, 8'h01};  // 1000 -> 1,0,0,0

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0;
      sr[i] = 1'b1;
      ld[i] = 8'h00;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      check("rst_valid", {7'd0, sv[i]}, 8'd0);
      check("rst_last", {7'd0, sl[i]}, 8'd0);
      check("rst_out", {7'd0, so[i]}, {7'd0, idle_bit[i]});
      check("rst_ready", {7'd0, lr[i]}, 8'd0);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) check("post_rst_ready", {7'd0, lr[i]}, 8'd1);

    for (int v = 0; v < 6; v++) begin
      load(vecs[v].inst, vecs[v].data, vecs[v].exp, 1'b0, 1'b0);
      drain(vecs[v].inst);
    end

    // Backpressure: stall three cycles with the third bit (0) on the output.
    load(0, 8'h0C, 8'h03, 1'b0, 1'b0);
    tick();
    tick();
    sr[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_out", {6'd0, sv[0], so[0]}, 8'b10);
      check("stall_last", {7'd0, sl[0]}, 8'd0);
    end
    sr[0] = 1'b1;
    drain(0);

    // Back-to-back words with load_valid held high.
    load(0, 8'h09, 8'h09, 1'b1, 1'b0);
    load(0, 8'h06, 8'h06, 1'b0, 1'b1);
    drain(0);

    // Reset in the middle of a word.
    load(1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    q.delete();
    check("midrst_valid", {7'd0, sv[1]}, 8'd0);
    check("midrst_out", {7'd0, so[1]}, {7'd0, idle_bit[1]});
    check("midrst_ready", {7'd0, lr[1]}, 8'd0);
    tick();
    check("midrst_ready_hold", {7'd0, lr[1]}, 8'd0);
    rst_n = 1'b1;
    #1;
    check("midrst_release_ready", {7'd0, lr[1]}, 8'd1);
    load(1, 8'h81, 8'h81, 1'b0, 1'b0);
    drain(1);

    // WIDTH=1 back-to-back: 1, 0, 1.
    load(2, 8'h01, 8'h01, 1'b1, 1'b0);
    load(2, 8'h00, 8'h00, 1'b1, 1'b1);
    load(2, 8'h01, 8'h01, 1'b0, 1'b1);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in serial-out shift register with a ready/valid handshake on both sides.
- Accepts a WIDTH-bit word on the load side and emits it one bit per accepted transfer on the serial side.
- Bit order is configurable; ser_last marks the final bit; serial-side backpressure is supported.
- Successor to the fixed 4-bit, select-driven PISO: adds width, bit order, flow control and gap-free back-to-back loading.

Parameters:
- WIDTH, 8, word width in bits; legal range is 1 to 64.
- MSB_FIRST, 1, 1 sends d[WIDTH-1] first; 0 sends d[0] first.
- IDLE_BIT, 0, value driven on ser_out when ser_valid is 0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- load_data  input  WIDTH  parallel word.
- ser_valid  output  1  ser_out holds a valid bit.
- ser_ready  input  1  downstream accepts the bit this cycle.
- ser_out  output  1  serial data bit.
- ser_last  output  1  current bit is the final bit of the word.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_valid=0, ser_last=0, ser_out=IDLE_BIT.
  - load_ready is forced to 0 while rst_n is low.
  - Reset mid-word discards the remaining bits; no partial word is resumed.
- Transfers:
  - Load transfer: load_valid & load_ready at a clk edge.
  - Serial transfer: ser_valid & ser_ready at a clk edge.
- States:
  - IDLE: load_ready=1, ser_valid=0. A load transfer moves to SHIFT.
  - SHIFT: ser_valid=1. Each serial transfer advances one bit. The serial transfer with ser_last=1 goes to IDLE, or stays in SHIFT if a load transfer happens in the same cycle.
- load_ready is combinational: (state==IDLE) | (state==SHIFT & ser_last & ser_ready), gated by rst_n.
- Latency: the first bit appears on ser_out, with ser_valid=1, in the cycle after the load transfer.
  - Back-to-back words have zero gap bits: bit 0 of the next word follows the last bit of the current word directly.
- Shift register:
  - MSB_FIRST=1: ser_out = sreg[WIDTH-1]; shift left and fill 0 on each serial transfer.
  - MSB_FIRST=0: ser_out = sreg[0]; shift right and fill 0.
- Counter:
  - Width is max(1, $clog2(WIDTH)).
  - Cleared on a load transfer; increments on a serial transfer.
  - ser_last = SHIFT & (counter == WIDTH-1).
- Backpressure: with ser_ready=0, ser_out, ser_last and the counter all hold.
- ser_valid never drops in SHIFT before the last bit is accepted.
- load_valid asserted in SHIFT while load_ready=0 has no effect.
- The sender must hold load_data until the load transfer completes.
- WIDTH=1: ser_last=1 whenever ser_valid=1; every accepted bit allows a new load in the same cycle.
- ser_out equals IDLE_BIT in IDLE.
- No arithmetic on data; the counter never wraps, because it is cleared by each load.

Decomposition:
- Package piso_pkg holds:
  - the state typedef (IDLE, SHIFT), 1-bit encoded;
  - a cnt_w(width) helper function returning max(1, $clog2(width)).
- One sub-module, piso_bit_cnt: parametrised counter with clear, increment and last-flag outputs, reused by future serializers.
- The shift and mux logic stays inline in piso_stream.

Test Plan:
- Basic MSB-first: WIDTH=4, MSB_FIRST=1, load 4'b1011, ser_ready=1.
  - ser_out = 1,0,1,1 on the four cycles after the load; ser_last high only on the 4th bit.
  - Then ser_valid=0 and ser_out=0.
- LSB-first: WIDTH=8, MSB_FIRST=0, load 8'hA5.
  - Bits 1,0,1,0,0,1,0,1; load_ready=0 during bits 1-7 and 1 on bit 8.
- Backpressure: WIDTH=4, load 4'b1100, hold ser_ready=0 for 3 cycles after bit 2.
  - ser_out stays at bit 2 (0) with ser_valid=1 during the stall; the stream resumes with 0.
  - Total output is 1,1,0,0; no bit is lost or duplicated.
- Back-to-back: WIDTH=4, load_valid held high with 4'b1001, then 4'b0110.
  - 8 contiguous valid bits 1,0,0,1,0,1,1,0; the second load transfer coincides with the first ser_last.
- Reset mid-word: WIDTH=8, load 8'hFF, assert rst_n=0 after 3 bits.
  - The next edge gives ser_valid=0, ser_out=IDLE_BIT, and load_ready=0 while reset is low.
  - After release, load_ready=1 and a fresh load of 8'h81 emits 1,0,0,0,0,0,0,1.
- WIDTH=1: load 1, 0, 1 back-to-back with ser_ready=1.
  - ser_out = 1,0,1 with ser_last=1 on every bit and load_ready=1 on every cycle.
